// File: rtl/tcam_lpm_search_if.sv
// Search-request / search-result bundle between the TCAM control group and the
// longest-prefix-match stage. The control side uses master, the search stage uses slave.
interface tcam_lpm_search_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LEN_WIDTH  = 6,
    parameter int unsigned INDEX_SIZE = 3
);
    logic                  go;
    logic [WIDTH-1:0]      key;
    logic [7:0]            valid;
    logic [WIDTH-1:0]      entry0, entry1, entry2, entry3;
    logic [WIDTH-1:0]      entry4, entry5, entry6, entry7;
    logic [LEN_WIDTH-1:0]  len0, len1, len2, len3, len4, len5, len6, len7;
    logic                  busy;
    logic                  done;
    logic                  hit;
    logic [INDEX_SIZE-1:0] index;
    logic [LEN_WIDTH-1:0]  match_len;

    modport master (
        output go, key, valid,
        output entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7,
        output len0, len1, len2, len3, len4, len5, len6, len7,
        input  busy, done, hit, index, match_len
    );

    modport slave (
        input  go, key, valid,
        input  entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7,
        input  len0, len1, len2, len3, len4, len5, len6, len7,
        output busy, done, hit, index, match_len
    );
endinterface

// File: rtl/tcam_lpm_search.sv
// Longest-prefix-match search over the 8 parallel read ports of the TCAM memory.
// A go in IDLE snapshots all inputs; the scan picks the valid entry with the longest
// (clamped) prefix that matches the key, lowest index winning ties.
// Build option: define TCAM_LPM_FAST_EN for a single-cycle parallel scan (priority tree);
// otherwise one comparator walks the entries over 8 cycles.
module tcam_lpm_search #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LEN_WIDTH  = 6,
    parameter int unsigned INDEX_SIZE = 3
) (
    input logic                clk,
    input logic                reset,
    tcam_lpm_search_if.slave   bus
);
    localparam int unsigned NUM_ENTRIES = 8;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]     entry_in [NUM_ENTRIES];
    logic [LEN_WIDTH-1:0] len_in   [NUM_ENTRIES];

    logic [WIDTH-1:0]     key_q;
    logic [7:0]           valid_q;
    logic [WIDTH-1:0]     entry_q [NUM_ENTRIES];
    logic [LEN_WIDTH-1:0] len_q   [NUM_ENTRIES];

    logic                  res_hit_q;
    logic [INDEX_SIZE-1:0] res_idx_q;
    logic [LEN_WIDTH-1:0]  res_len_q;

    logic                  scan_hit;
    logic [INDEX_SIZE-1:0] scan_idx;
    logic [LEN_WIDTH-1:0]  scan_len;
    logic                  scan_last;

    logic accept;

    // Lengths beyond the key width mean an exact match.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (32'(len) > WIDTH) return LEN_WIDTH'(WIDTH);
        return len;
    endfunction

    // Compare only the leading l bits; l=0 yields an all-zero mask, i.e. the default route.
    function automatic logic prefix_match(input logic [WIDTH-1:0] k,
                                          input logic [WIDTH-1:0] e,
                                          input logic [LEN_WIDTH-1:0] l);
        logic [WIDTH-1:0] mask;
        mask = {WIDTH{1'b1}} << (WIDTH - 32'(l));
        return ((k ^ e) & mask) == '0;
    endfunction

    // Gather the flat read ports into arrays for indexed access.
    always_comb begin
        entry_in[0] = bus.entry0; entry_in[1] = bus.entry1;
        entry_in[2] = bus.entry2; entry_in[3] = bus.entry3;
        entry_in[4] = bus.entry4; entry_in[5] = bus.entry5;
        entry_in[6] = bus.entry6; entry_in[7] = bus.entry7;
        len_in[0]   = bus.len0;   len_in[1]   = bus.len1;
        len_in[2]   = bus.len2;   len_in[3]   = bus.len3;
        len_in[4]   = bus.len4;   len_in[5]   = bus.len5;
        len_in[6]   = bus.len6;   len_in[7]   = bus.len7;
    end

    assign accept = (state_q == StIdle) && bus.go;

`ifdef TCAM_LPM_FAST_EN
    // Parallel scan: priority tree over all entries, strictly-greater keeps the lowest index.
    always_comb begin
        logic [LEN_WIDTH-1:0] l;
        scan_hit  = 1'b0;
        scan_idx  = '0;
        scan_len  = '0;
        scan_last = 1'b1;
        l         = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            l = clamp_len(len_q[i]);
            if (valid_q[i] && prefix_match(key_q, entry_q[i], l) && (!scan_hit || l > scan_len)) begin
                scan_hit = 1'b1;
                scan_idx = INDEX_SIZE'(i);
                scan_len = l;
            end
        end
    end
`else
    logic [INDEX_SIZE-1:0] ctr_q;
    logic                  best_hit_q;
    logic [INDEX_SIZE-1:0] best_idx_q;
    logic [LEN_WIDTH-1:0]  best_len_q;
    logic [LEN_WIDTH-1:0]  cand_len;
    logic                  cand_hit;

    // Single comparator on the entry selected by the scan counter; fold into the running best.
    always_comb begin
        cand_len  = clamp_len(len_q[ctr_q]);
        cand_hit  = valid_q[ctr_q] && prefix_match(key_q, entry_q[ctr_q], cand_len);
        scan_hit  = best_hit_q;
        scan_idx  = best_idx_q;
        scan_len  = best_len_q;
        scan_last = (ctr_q == INDEX_SIZE'(NUM_ENTRIES - 1));
        if (cand_hit && (!best_hit_q || cand_len > best_len_q)) begin
            scan_hit = 1'b1;
            scan_idx = ctr_q;
            scan_len = cand_len;
        end
    end

    // Scan counter and running best; cleared when a search is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctr_q      <= '0;
            best_hit_q <= 1'b0;
            best_idx_q <= '0;
            best_len_q <= '0;
        end else if (accept) begin
            ctr_q      <= '0;
            best_hit_q <= 1'b0;
            best_idx_q <= '0;
            best_len_q <= '0;
        end else if (state_q == StScan) begin
            ctr_q      <= ctr_q + 1'b1;
            best_hit_q <= scan_hit;
            best_idx_q <= scan_idx;
            best_len_q <= scan_len;
        end
    end
`endif

    // FSM next state: IDLE -> SCAN -> DONE -> IDLE; go only matters in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.go) state_d = StScan;
            StScan:  if (scan_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Snapshot of the search inputs, so later input changes cannot disturb a running scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= '0;
                len_q[i]   <= '0;
            end
        end else if (accept) begin
            key_q   <= bus.key;
            valid_q <= bus.valid;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= entry_in[i];
                len_q[i]   <= len_in[i];
            end
        end
    end

    // Result registers: cleared on accept, loaded at the end of the scan, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_hit_q <= 1'b0;
            res_idx_q <= '0;
            res_len_q <= '0;
        end else if (accept) begin
            res_hit_q <= 1'b0;
            res_idx_q <= '0;
            res_len_q <= '0;
        end else if (state_q == StScan && scan_last) begin
            res_hit_q <= scan_hit;
            res_idx_q <= scan_idx;
            res_len_q <= scan_len;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.hit       = res_hit_q;
    assign bus.index     = res_idx_q;
    assign bus.match_len = res_len_q;
endmodule

// File: tb/tb_tcam_lpm_search.sv
// Bench for tcam_lpm_search: directed vector table, randomized searches against a
// prefix-length reference model, and hand sequences for abort, snapshot and back-to-back go.
module tb_tcam_lpm_search;
`ifdef TCAM_LPM_FAST_EN
    localparam int LAT = 2;
    localparam int PERIOD = 3;
`else
    localparam int LAT = 9;
    localparam int PERIOD = 10;
`endif

    typedef struct {
        string             name;
        logic [31:0]       key;
        logic [7:0]        valid;
        logic [7:0][31:0]  ent;
        logic [7:0][5:0]   len;
        logic              hit;
        logic [2:0]        idx;
        logic [5:0]        mlen;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    tcam_lpm_search_if #(.WIDTH(32), .LEN_WIDTH(6), .INDEX_SIZE(3)) bus ();

    tcam_lpm_search #(.WIDTH(32), .LEN_WIDTH(6), .INDEX_SIZE(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, want);
    endtask

    task automatic apply(input vec_t v);
        bus.key = v.key;  bus.valid = v.valid;
        bus.entry0 = v.ent[0]; bus.entry1 = v.ent[1]; bus.entry2 = v.ent[2]; bus.entry3 = v.ent[3];
        bus.entry4 = v.ent[4]; bus.entry5 = v.ent[5]; bus.entry6 = v.ent[6]; bus.entry7 = v.ent[7];
        bus.len0 = v.len[0]; bus.len1 = v.len[1]; bus.len2 = v.len[2]; bus.len3 = v.len[3];
        bus.len4 = v.len[4]; bus.len5 = v.len[5]; bus.len6 = v.len[6]; bus.len7 = v.len[7];
    endtask

    // Reference: longest clamped prefix among matching valid entries, then its lowest index.
    task automatic ref_model(input vec_t v, output logic h, output logic [2:0] ix,
                             output logic [5:0] ml);
        int lens[8];
        bit m[8];
        int best = -1;
        for (int i = 0; i < 8; i++) begin
            lens[i] = (v.len[i] > 6'd32) ? 32 : int'(v.len[i]);
            m[i] = v.valid[i] &&
                   ((64'(v.key) >> (32 - lens[i])) == (64'(v.ent[i]) >> (32 - lens[i])));
            if (m[i] && lens[i] > best) best = lens[i];
        end
        h = 1'b0; ix = 3'd0; ml = 6'd0;
        if (best >= 0) begin
            h = 1'b1;
            ml = 6'(best);
            for (int i = 7; i >= 0; i--) if (m[i] && lens[i] == best) ix = 3'(i);
        end
    endtask

    // Called at a negedge with inputs applied. Returns latency in cycles from E0 and the
    // results seen with done; post_ok says results held and done/busy dropped one cycle later.
    task automatic run_search(input bit corrupt, output int lat, output logic h,
                              output logic [2:0] ix, output logic [5:0] ml, output logic post_ok);
        bus.go = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.go = 1'b0;
        if (corrupt) begin
            bus.entry5 = 32'hFFFF_FFFF; bus.len5 = 6'd8;
            bus.entry3 = 32'h0000_0000; bus.len3 = 6'd32;
            bus.valid = 8'h00;
        end
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        h = bus.hit; ix = bus.index; ml = bus.match_len;
        @(posedge clk);
        @(negedge clk);
        post_ok = !bus.done && !bus.busy && bus.hit === h && bus.index === ix
                  && bus.match_len === ml;
    endtask

    vec_t tbl[5];
    vec_t t1;

    initial begin
        int lat;
        logic h, eh, pok;
        logic [2:0] ix, eix;
        logic [5:0] ml, eml;
        bit seen;
        int t;

        // Directed table.
        t1.name = "lpm24"; t1.key = 32'hC0A8_0105; t1.valid = 8'hFF;
        for (int i = 0; i < 8; i++) begin t1.ent[i] = 32'hDEAD_0000 + 32'(i); t1.len[i] = 6'd32; end
        t1.ent[3] = 32'hC0A8_0000; t1.len[3] = 6'd16;
        t1.ent[5] = 32'hC0A8_0100; t1.len[5] = 6'd24;
        t1.hit = 1'b1; t1.idx = 3'd5; t1.mlen = 6'd24;
        tbl[0] = t1;

        tbl[1].name = "tie"; tbl[1].key = 32'h0A0B_0C0D; tbl[1].valid = 8'h42;
        for (int i = 0; i < 8; i++) begin tbl[1].ent[i] = 32'h0; tbl[1].len[i] = 6'd0; end
        tbl[1].ent[1] = 32'h0A00_0000; tbl[1].len[1] = 6'd8;
        tbl[1].ent[6] = 32'h0A00_0000; tbl[1].len[6] = 6'd8;
        tbl[1].hit = 1'b1; tbl[1].idx = 3'd1; tbl[1].mlen = 6'd8;

        tbl[2] = t1; tbl[2].name = "none"; tbl[2].valid = 8'h00;
        tbl[2].hit = 1'b0; tbl[2].idx = 3'd0; tbl[2].mlen = 6'd0;

        tbl[3].name = "clamp"; tbl[3].key = 32'h1234_5678; tbl[3].valid = 8'h05;
        for (int i = 0; i < 8; i++) begin tbl[3].ent[i] = 32'hFFFF_FFFF; tbl[3].len[i] = 6'd32; end
        tbl[3].ent[0] = 32'hAAAA_5555; tbl[3].len[0] = 6'd0;
        tbl[3].ent[2] = 32'h1234_5678; tbl[3].len[2] = 6'd40;
        tbl[3].hit = 1'b1; tbl[3].idx = 3'd2; tbl[3].mlen = 6'd32;

        tbl[4] = tbl[3]; tbl[4].name = "default_route"; tbl[4].key = 32'h1234_5679;
        tbl[4].hit = 1'b1; tbl[4].idx = 3'd0; tbl[4].mlen = 6'd0;

        bus.go = 1'b0;
        apply(t1);

        // Reset state.
        #1;
        check("reset_busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
        check("reset_results", {54'b0, bus.hit, bus.index, bus.match_len}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[k]) begin
            apply(tbl[k]);
            run_search(1'b0, lat, h, ix, ml, pok);
            check({tbl[k].name, "_latency"}, 64'(lat), 64'(LAT));
            check({tbl[k].name, "_result"}, {54'b0, h, ix, ml},
                  {54'b0, tbl[k].hit, tbl[k].idx, tbl[k].mlen});
            check({tbl[k].name, "_hold"}, {63'b0, pok}, 64'd1);
        end

        // Randomized searches; entries are perturbed copies of the key so matches are common.
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v.name = "rand";
            v.key = $urandom();
            v.valid = 8'($urandom());
            for (int i = 0; i < 8; i++) begin
                v.ent[i] = v.key ^ ($urandom() >> $urandom_range(0, 32));
                v.len[i] = 6'($urandom_range(0, 63));
            end
            ref_model(v, eh, eix, eml);
            apply(v);
            run_search(1'b0, lat, h, ix, ml, pok);
            check("rand_latency", 64'(lat), 64'(LAT));
            check("rand_result", {54'b0, h, ix, ml}, {54'b0, eh, eix, eml});
        end

        // Abort: reset during the scan gives no done and zero outputs; next search works.
        apply(t1);
        bus.go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.go = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_outputs", {53'b0, bus.busy, bus.done, bus.hit, bus.index, bus.match_len},
              64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort_no_done", {63'b0, seen}, 64'd0);
        run_search(1'b0, lat, h, ix, ml, pok);
        check("after_abort_latency", 64'(lat), 64'(LAT));
        check("after_abort_result", {54'b0, h, ix, ml}, {54'b0, 1'b1, 3'd5, 6'd24});

        // Snapshot: inputs trashed right after E0 must not affect the result.
        apply(t1);
        run_search(1'b1, lat, h, ix, ml, pok);
        check("snapshot_result", {54'b0, h, ix, ml}, {54'b0, 1'b1, 3'd5, 6'd24});

        // go held high: back-to-back searches.
        apply(t1);
        bus.go = 1'b1;
        t = 0;
        while (!bus.done && t < 40) begin @(posedge clk); t++; @(negedge clk); end
        check("held_go_first_done", {63'b0, bus.done}, 64'd1);
        t = 0;
        do begin @(posedge clk); t++; @(negedge clk); end while (!bus.done && t < 40);
        check("held_go_period", 64'(t), 64'(PERIOD));
        check("held_go_result", {54'b0, bus.hit, bus.index, bus.match_len},
              {54'b0, 1'b1, 3'd5, 6'd24});
        bus.go = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
